// File: rtl/mem_byte_sequencer.sv
// Byte-wide external memory sequencer: splits byte/half/word loads and stores
// into little-endian byte beats, assembles and extends load data, and pulses ready once per request.
module mem_byte_sequencer #(
   parameter logic [31:0] IO_BASE       = 32'h0003_0000,
   parameter int          BUS_ADDR_BITS = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        flush,
   input  logic        valid,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [2:0]  len,
   input  logic [31:0] data,
   output logic        ready,
   output logic [31:0] res,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                   state_reg, state_next;
   logic [31:0]              addr_reg, addr_next;
   logic [2:0]               len_reg, len_next;
   logic [31:0]              data_reg, data_next;
   logic [2:0]               cnt_reg, cnt_next;
   logic [31:0]              res_reg, res_next;
   logic [BUS_ADDR_BITS-1:0] mem_a_reg, mem_a_next;
   logic [7:0]               mem_dout_reg, mem_dout_next;
   logic                     mem_wr_reg, mem_wr_next;
   logic                     ready_reg, ready_next;
   logic                     flushed_reg, flushed_next;

   logic [2:0]               beats;
   logic [2:0]               beat_idx;
   logic [2:0]               cap_idx;
   logic [BUS_ADDR_BITS-1:0] beat_addr;
   logic [31:0]              asm_word;
   logic [7:0]               data_byte [4];
   logic                     io_stall_new;
   logic                     io_stall_cur;

   assign beats        = len_reg[1] ? 3'd4 : (len_reg[0] ? 3'd2 : 3'd1);
   // In READ, cnt_reg counts cycles since the first address went out, so the next issue is cnt+1.
   assign beat_idx     = (state_reg == READ) ? cnt_reg + 3'd1 : cnt_reg;
   assign beat_addr    = addr_reg[BUS_ADDR_BITS-1:0] + BUS_ADDR_BITS'(beat_idx);
   assign cap_idx      = cnt_reg - 3'd1;
   assign io_stall_new = (addr >= IO_BASE) && io_buffer_full;
   assign io_stall_cur = (addr_reg >= IO_BASE) && io_buffer_full;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
         assign data_byte[gi]         = data_reg[8*gi +: 8];
         assign asm_word[8*gi +: 8]   = (cap_idx == 3'(gi)) ? mem_din : res_reg[8*gi +: 8];
      end
   endgenerate

   function automatic logic [31:0] extend(input logic [2:0] l, input logic [31:0] w);
      case (l)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'd0, w[7:0]};
         3'b101:  return {16'd0, w[15:0]};
         default: return w;
      endcase
   endfunction

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      len_next      = len_reg;
      data_next     = data_reg;
      cnt_next      = cnt_reg;
      res_next      = res_reg;
      mem_a_next    = mem_a_reg;
      mem_dout_next = mem_dout_reg;
      mem_wr_next   = 1'b0;
      ready_next    = 1'b0;
      flushed_next  = flushed_reg;
      case (state_reg)
         IDLE: begin
            if (valid && !flush) begin
               addr_next    = addr;
               len_next     = len;
               data_next    = data;
               mem_a_next   = addr[BUS_ADDR_BITS-1:0];
               flushed_next = 1'b0;
               cnt_next     = 3'd0;
               if (wr) begin
                  state_next = WRITE;
                  if (!io_stall_new) begin
                     mem_wr_next   = 1'b1;
                     mem_dout_next = data[7:0];
                     cnt_next      = 3'd1;
                  end
               end else begin
                  state_next = READ;
               end
            end
         end
         READ: begin
            if (flush) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 3'd1;
               if (cnt_reg + 3'd1 < beats)
                  mem_a_next = beat_addr;
               if (cnt_reg != 3'd0)
                  res_next = asm_word;
               if (cnt_reg == beats) begin
                  res_next   = extend(len_reg, asm_word);
                  state_next = DONE;
                  ready_next = 1'b1;
               end
            end
         end
         WRITE: begin
            // A flushed store still completes every beat; only its ready is dropped.
            if (flush)
               flushed_next = 1'b1;
            if (cnt_reg == beats) begin
               if (flushed_reg || flush) begin
                  state_next = IDLE;
               end else begin
                  state_next = DONE;
                  ready_next = 1'b1;
               end
            end else if (!io_stall_cur) begin
               mem_a_next    = beat_addr;
               mem_dout_next = data_byte[cnt_reg[1:0]];
               mem_wr_next   = 1'b1;
               cnt_next      = cnt_reg + 3'd1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         len_reg      <= '0;
         data_reg     <= '0;
         cnt_reg      <= '0;
         res_reg      <= '0;
         mem_a_reg    <= '0;
         mem_dout_reg <= '0;
         mem_wr_reg   <= 1'b0;
         ready_reg    <= 1'b0;
         flushed_reg  <= 1'b0;
      end else if (rdy) begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         len_reg      <= len_next;
         data_reg     <= data_next;
         cnt_reg      <= cnt_next;
         res_reg      <= res_next;
         mem_a_reg    <= mem_a_next;
         mem_dout_reg <= mem_dout_next;
         mem_wr_reg   <= mem_wr_next;
         ready_reg    <= ready_next;
         flushed_reg  <= flushed_next;
      end else if (state_reg == READ) begin
         // Paused reads restart from byte 0 so resume presents addr in its first cycle.
         cnt_reg   <= 3'd0;
         mem_a_reg <= addr_reg[BUS_ADDR_BITS-1:0];
      end
   end

   assign mem_a    = {{(32-BUS_ADDR_BITS){1'b0}}, mem_a_reg};
   assign mem_dout = mem_dout_reg;
   assign mem_wr   = mem_wr_reg & rdy;
   assign ready    = ready_reg & rdy & ~flush;
   assign res      = res_reg;
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: a byte RAM model plus a transaction-level reference that
// predicts every bus beat, read address and ready pulse, checked once per cycle.
module tb_mem_byte_sequencer;
   localparam logic [31:0] IO_BASE = 32'h0003_0000;
   localparam int          AB      = 18;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, valid, wr, io_buffer_full;
   logic [31:0] addr, data;
   logic [2:0]  len;
   logic        ready, mem_wr;
   logic [31:0] res, mem_a;
   logic [7:0]  mem_din, mem_dout;

   mem_byte_sequencer #(.IO_BASE(IO_BASE), .BUS_ADDR_BITS(AB)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .valid(valid), .wr(wr),
      .addr(addr), .len(len), .data(data), .ready(ready), .res(res),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] ram       [0:(1<<AB)-1];
   logic [7:0] model_ram [0:(1<<AB)-1];

   always @(posedge clk) begin
      mem_din <= ram[mem_a[AB-1:0]];
      if (mem_wr) ram[mem_a[AB-1:0]] <= mem_dout;
   end

   int n_chk = 0;
   int n_pass = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
   endtask

   // Expected per-cycle events, keyed by absolute cycle number.
   logic [31:0] exp_wr_a [int];
   logic [7:0]  exp_wr_d [int];
   logic [31:0] exp_rd_a [int];
   bit          exp_rdy  [int];
   logic [31:0] exp_res  [int];

   bit          chk_on   = 1'b0;
   int          rdy_cnt  = 0;
   logic [31:0] last_res = '0;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("mem_wr", {31'd0, mem_wr}, exp_wr_a.exists(cyc) ? 32'd1 : 32'd0);
         if (mem_wr && exp_wr_a.exists(cyc)) begin
            chk("wr_addr", mem_a, exp_wr_a[cyc]);
            chk("wr_data", {24'd0, mem_dout}, {24'd0, exp_wr_d[cyc]});
         end
         if (exp_rd_a.exists(cyc)) chk("rd_addr", mem_a, exp_rd_a[cyc]);
         chk("ready", {31'd0, ready}, exp_rdy.exists(cyc) ? 32'd1 : 32'd0);
         if (ready && exp_res.exists(cyc)) chk("res", res, exp_res[cyc]);
         chk("mem_a_hi", {18'd0, mem_a[31:18]}, 32'd0);
         if (ready) begin
            rdy_cnt++;
            last_res = res;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int beats_of(input logic [2:0] l);
      case (l[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   // One request accepted at the current cycle. full_n: cycles of io_buffer_full from accept;
   // r_lo/l_lo: rdy low from relative cycle r_lo for l_lo cycles; fl: relative flush cycle (-1 none).
   task automatic run_req(input bit w, input logic [2:0] l, input logic [31:0] ad, input logic [31:0] d,
                          input int full_n, input int r_lo, input int l_lo, input int fl);
      int a, n, t, last, end_rel, rc;
      bit io;
      logic [31:0] raw, v, ba;
      n    = beats_of(l);
      io   = (ad >= IO_BASE);
      a    = cyc;
      rc   = rdy_cnt;
      last = 0;
      if (w) begin
         for (int i = 0; i < n; i++) begin
            ba = ad + 32'(i);
            t  = 1 + i + (io ? full_n : 0) + ((r_lo > 0 && i >= r_lo - 1) ? l_lo : 0);
            exp_wr_a[a+t] = {14'd0, ba[17:0]};
            exp_wr_d[a+t] = d[8*i +: 8];
            model_ram[ba[17:0]] = d[8*i +: 8];
            last = t;
         end
         if (fl < 0) begin
            exp_rdy[a+last+1] = 1'b1;
            end_rel = last + 1;
         end else begin
            end_rel = last;
         end
      end else begin
         t   = (r_lo > 0) ? r_lo + l_lo : 1;
         raw = '0;
         for (int i = 0; i < n; i++) begin
            ba = ad + 32'(i);
            raw[8*i +: 8] = model_ram[ba[17:0]];
            if (fl >= 0 ? (1 + i <= fl) : (r_lo > 0 ? (1 + i < r_lo) : 1'b1))
               exp_rd_a[a+1+i] = {14'd0, ba[17:0]};
            if (fl < 0 && r_lo > 0)
               exp_rd_a[a+t+i] = {14'd0, ba[17:0]};
         end
         case (l)
            3'b000:  v = raw[7]  ? (raw | 32'hFFFF_FF00) : raw;
            3'b001:  v = raw[15] ? (raw | 32'hFFFF_0000) : raw;
            default: v = raw;
         endcase
         if (fl < 0) begin
            exp_rdy[a+t+n+1] = 1'b1;
            exp_res[a+t+n+1] = v;
            end_rel = t + n + 1;
         end else begin
            end_rel = fl;
         end
      end
      for (int rel = 0; rel <= end_rel; rel++) begin
         valid = (fl < 0 || rel < fl);
         wr    = w;
         len   = l;
         addr  = ad;
         data  = d;
         flush = (rel == fl);
         rdy   = !(r_lo > 0 && rel >= r_lo && rel < r_lo + l_lo);
         if (rel < full_n)  io_buffer_full = 1'b1;
         else if (w && io)  io_buffer_full = 1'b0;
         else               io_buffer_full = 1'($urandom_range(0, 1));
         step();
      end
      valid = 1'b0; flush = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
      chk("ready_count", rdy_cnt - rc, (fl < 0) ? 1 : 0);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         valid = 1'b0;
         rdy   = 1'($urandom_range(0, 1));
         io_buffer_full = 1'($urandom_range(0, 1));
         step();
      end
      rdy = 1'b1; io_buffer_full = 1'b0;
   endtask

   initial begin
      bit          w;
      logic [2:0]  l;
      logic [31:0] ad, d;
      int          n, mode, full_n, r_lo, l_lo, fl, rc;

      for (int i = 0; i < (1 << AB); i++) begin
         ram[i]       = 8'(i * 37 + 11);
         model_ram[i] = 8'(i * 37 + 11);
      end
      ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
      ram[32'h1FF] = 8'h34; ram[32'h200] = 8'h80;
      model_ram[32'h100] = 8'h78; model_ram[32'h101] = 8'h56;
      model_ram[32'h102] = 8'h34; model_ram[32'h103] = 8'h12;
      model_ram[32'h1FF] = 8'h34; model_ram[32'h200] = 8'h80;

      rst = 1'b1; rdy = 1'b1; flush = 1'b0; valid = 1'b0; wr = 1'b0;
      addr = '0; len = '0; data = '0; io_buffer_full = 1'b0;
      step(); step(); step();
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_res", res, 32'd0);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      rst = 1'b0;
      chk_on = 1'b1;
      step();

      run_req(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 0, -1);
      chk("lw_0x100", last_res, 32'h1234_5678);
      run_req(1'b0, 3'b000, 32'h200, 32'h0, 0, 0, 0, -1);
      chk("lb_0x200", last_res, 32'hFFFF_FF80);
      run_req(1'b0, 3'b100, 32'h200, 32'h0, 0, 0, 0, -1);
      chk("lbu_0x200", last_res, 32'h0000_0080);
      run_req(1'b0, 3'b001, 32'h1FF, 32'h0, 0, 0, 0, -1);
      chk("lh_0x1ff", last_res, 32'hFFFF_8034);
      run_req(1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 0, 0, 0, -1);
      run_req(1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 0, -1);
      chk("sw_readback", last_res, 32'hDEAD_BEEF);
      run_req(1'b1, 3'b000, 32'h3_0000, 32'h41, 3, 0, 0, -1);
      run_req(1'b0, 3'b100, 32'h3_0000, 32'h0, 0, 0, 0, -1);
      chk("sb_io_readback", last_res, 32'h0000_0041);
      run_req(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 0, 2);
      run_req(1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 0, 0, 0, 2);
      run_req(1'b0, 3'b010, 32'h400, 32'h0, 0, 0, 0, -1);
      chk("flushed_sw_readback", last_res, 32'hCAFE_F00D);
      run_req(1'b0, 3'b010, 32'h100, 32'h0, 0, 3, 2, -1);
      chk("rdy_lo_lw", last_res, 32'h1234_5678);
      run_req(1'b1, 3'b010, 32'h500, 32'h1122_3344, 0, 2, 2, -1);
      run_req(1'b0, 3'b010, 32'h500, 32'h0, 0, 0, 0, -1);
      chk("rdy_lo_sw_readback", last_res, 32'h1122_3344);

      rc = rdy_cnt;
      valid = 1'b1; wr = 1'b1; len = 3'b010; addr = 32'h600; flush = 1'b1;
      step();
      valid = 1'b0; flush = 1'b0;
      step(); step(); step();
      chk("idle_flush_ignored", rdy_cnt - rc, 0);

      for (int k = 0; k < 150; k++) begin
         w = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0:       l = 3'b000;
            1:       l = 3'b001;
            2:       l = 3'b010;
            3:       l = 3'b100;
            default: l = 3'b101;
         endcase
         if (w) l = {1'b0, l[1:0]};
         case ($urandom_range(0, 2))
            0:       ad = $urandom_range(0, 32'h2_FFFF);
            1:       ad = $urandom_range(32'h3_0000, 32'h3_FFFF);
            default: ad = 32'hFFFF_FFF0 + $urandom_range(0, 15);
         endcase
         d = $urandom;
         n = beats_of(l);
         full_n = 0; r_lo = 0; l_lo = 0; fl = -1;
         mode = $urandom_range(0, 3);
         case (mode)
            1: full_n = $urandom_range(1, 3);
            2: begin
               r_lo = $urandom_range(1, w ? n : n + 1);
               l_lo = $urandom_range(1, 3);
            end
            3: fl = $urandom_range(1, w ? n : n + 1);
            default: ;
         endcase
         run_req(w, l, ad, d, full_n, r_lo, l_lo, fl);
         idle($urandom_range(0, 2));
      end

      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
